// File: rtl/frame_buffer_ctrl_if.sv
// rtl/frame_buffer_ctrl_if.sv - pixel input, BRAM write and buffer-select signals of the frame buffer controller
interface frame_buffer_ctrl_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
);
    logic              pix_valid;
    logic              pix_sof;
    logic [DATA_W-1:0] pix_data;
    logic              capture_en;
    logic              rd_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_buf;
    logic              swap;
    logic              frame_err;
    logic              busy;

    // Pixel source and reader status side
    modport master (
        output pix_valid, pix_sof, pix_data, capture_en, rd_busy,
        input  wr_en, wr_addr, wr_data, wr_buf, swap, frame_err, busy
    );

    // Controller side
    modport slave (
        input  pix_valid, pix_sof, pix_data, capture_en, rd_busy,
        output wr_en, wr_addr, wr_data, wr_buf, swap, frame_err, busy
    );
endinterface

// File: rtl/frame_buffer_ctrl.sv
// rtl/frame_buffer_ctrl.sv - 2:1 decimating write sequencer and ping-pong buffer arbiter
module frame_buffer_ctrl #(
    parameter int IN_W   = 640,
    parameter int IN_H   = 480,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
) (
    input  logic                clk,
    input  logic                reset,
    frame_buffer_ctrl_if.slave  bus
);
    localparam int XW = $clog2(IN_W);
    localparam int YW = $clog2(IN_H);
    localparam logic [XW-1:0] X_LAST = XW'(IN_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IN_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_SWAP_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_buf_q, wr_buf_d;
    logic              swap_q, swap_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;

    // Position of the pixel being accepted this cycle (a sof forces it to the origin)
    logic              take;
    logic [XW-1:0]     cx;
    logic [YW-1:0]     cy;
    logic [ADDR_W-1:0] ca;

    // State register and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_buf_q    <= 1'b0;
            swap_q      <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_buf_q    <= wr_buf_d;
            swap_q      <= swap_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state: frame sequencing, decimated write generation and buffer swap
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_buf_d    = wr_buf_q;
        swap_d      = 1'b0;
        frame_err_d = 1'b0;
        take        = 1'b0;
        cx          = x_q;
        cy          = y_q;
        ca          = addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.pix_valid && bus.pix_sof && bus.capture_en) begin
                    state_d = S_CAPTURE;
                    take    = 1'b1;
                    cx      = '0;
                    cy      = '0;
                    ca      = '0;
                end
            end
            S_CAPTURE: begin
                if (bus.pix_valid) begin
                    if (bus.pix_sof) begin
                        // Early start of frame: abandon the partial frame in place
                        frame_err_d = 1'b1;
                        x_d         = '0;
                        y_d         = '0;
                        addr_d      = '0;
                        if (bus.capture_en) begin
                            take = 1'b1;
                            cx   = '0;
                            cy   = '0;
                            ca   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        take = 1'b1;
                    end
                end
            end
            S_SWAP_WAIT: begin
                // Completed frame is held until the reader releases the other buffer
                if (!bus.rd_busy) begin
                    wr_buf_d = ~wr_buf_q;
                    swap_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (take) begin
            addr_d = ca;
            if (!cx[0] && !cy[0]) begin
                wr_en_d   = 1'b1;
                wr_addr_d = ca;
                wr_data_d = bus.pix_data;
                addr_d    = ca + ADDR_W'(1);
            end
            if (cx == X_LAST) begin
                x_d = '0;
                if (cy == Y_LAST) begin
                    y_d     = '0;
                    addr_d  = '0;
                    state_d = S_SWAP_WAIT;
                end else begin
                    y_d = cy + YW'(1);
                end
            end else begin
                x_d = cx + XW'(1);
                y_d = cy;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_buf    = wr_buf_q;
    assign bus.swap      = swap_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;
endmodule
